rv32i_mem_arbiter: RTL and testbench
====================================

Name: rv32i_mem_arbiter

Overview:
- Shares the single-port unified memory between the core's instruction-fetch port and its load/store port.
- Fetch and load/store are independent requesters. The arbiter issues at most one memory access per cycle and returns each response one cycle after issue.
- Load/store has fixed priority, with a starvation guard so fetch always makes progress.
- Out-of-range addresses are rejected with an error acknowledge; no memory access is made for them.

Parameters:
- MEMORY_DEPTH, 81920: memory size in bytes; legal byte addresses are 0..MEMORY_DEPTH-1.
- STARVE_LIMIT, 3: number of consecutive data grants made while fetch is waiting, after which fetch is forced ahead (1..15).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_inst_req  in  1  fetch request; held high with stable address until o_inst_ack.
- i_inst_addr  in  32  fetch byte address.
- o_inst_ack  out  1  one-cycle pulse: o_inst_data is valid.
- o_inst_data  out  32  fetched word.
- o_inst_err  out  1  with ack: address out of range.
- i_data_req  in  1  load/store request; held high with stable fields until o_data_ack.
- i_data_addr  in  32  load/store byte address.
- i_data_wr_en  in  1  1 = store, 0 = load.
- i_data_wr_mask  in  4  byte-lane write enables.
- i_data_wr  in  32  store data.
- o_data_ack  out  1  one-cycle pulse: access complete.
- o_data_rd  out  32  load data, valid with ack.
- o_data_err  out  1  with ack: address out of range.
- o_mem_addr  out  32  word-aligned byte address to memory.
- o_mem_wr_en  out  1  memory write strobe.
- o_mem_wr_mask  out  4  memory byte enables.
- o_mem_wr_data  out  32  memory write data.
- i_mem_rd_data  in  32  memory read data, registered (available the cycle after the address is presented).

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - All acks and errs = 0; o_mem_wr_en = 0; o_mem_addr = 0; mask = 0.
  - Data outputs = 0; issue state = IDLE; starvation counter = 0.
  - A reset in the middle of an access discards it; no ack follows the release of reset.
- Per-port state: each port is WAIT or ISSUED.
  - A port is eligible when its req is high and it is in WAIT.
  - Issue in cycle N sets the port to ISSUED.
  - In cycle N+1 the arbiter pulses that port's ack, returns the port to WAIT, and the port is not eligible that cycle.
  - Consequences: a single requester gets at most one access per two cycles. With both requesting, accesses alternate, giving one memory access per cycle.
- Grant decision (combinational, registered onto o_mem_* at the clock edge):
  - Only data eligible: grant data.
  - Only fetch eligible: grant fetch.
  - Both eligible: grant fetch if the starvation counter equals STARVE_LIMIT; otherwise grant data.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each data grant made while fetch is eligible.
  - Clears on a fetch grant, and whenever fetch is not requesting.
- Memory outputs:
  - o_mem_addr = {addr[31:2], 2'b00} of the granted port.
  - o_mem_wr_en = i_data_wr_en only for a data grant.
  - o_mem_wr_mask and o_mem_wr_data come from the data port on a store; they are 0 otherwise.
  - With no grant: o_mem_wr_en = 0, and the address holds its last value.
- Responses:
  - At N+1, a read ack carries i_mem_rd_data on o_inst_data or o_data_rd.
  - A store ack carries o_data_rd = 0.
  - Data outputs hold their value between acks.
- Range check: addr >= MEMORY_DEPTH.
  - The grant still consumes the cycle, but no memory strobe is asserted (wr_en = 0).
  - At N+1: ack = 1, err = 1, data = 0.
  - err is 0 whenever ack is 0.
- Dropped request: if req falls before its ack, the in-flight response is still acked; the requester ignores it.
- A new grant may be issued in the same cycle an ack is pulsed, to the other port.

Test Plan:
- Reset: hold i_rst_n=0 with both requests high -> all acks, errs and o_mem_wr_en stay 0. Release reset -> first data grant at the next edge, ack one cycle later.
- Lone fetch: addr 0x00000010, memory word 0x00000013 -> o_mem_addr=0x10, then o_inst_ack=1 with o_inst_data=0x00000013. Requester holds req -> the next ack follows 2 cycles later.
- Store then load: store 0xDEADBEEF to 0x1004 with mask 1111 -> o_mem_wr_en=1 for one cycle, then ack. Load from 0x1004 -> o_data_rd=0xDEADBEEF.
- Contention: both ports request continuously, STARVE_LIMIT=3 -> grants alternate D,I,D,I... Fetch is never stalled for more than STARVE_LIMIT data grants; check the counter's saturation path by delaying the fetch ack reset.
- Range error: data load at 0x00014000 (=MEMORY_DEPTH) -> no write strobe; o_data_ack=1, o_data_err=1, o_data_rd=0.
- Reset mid-access: assert i_rst_n=0 in the cycle after a fetch issue -> no o_inst_ack. After release, the held request is re-issued and acked normally.

Source files
------------

// File: rtl/rv32i_mem_arbiter_if.sv
// Fetch, load/store and memory bus signals of the unified-memory arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface rv32i_mem_arbiter_if;
    logic        i_inst_req;
    logic [31:0] i_inst_addr;
    logic        o_inst_ack;
    logic [31:0] o_inst_data;
    logic        o_inst_err;

    logic        i_data_req;
    logic [31:0] i_data_addr;
    logic        i_data_wr_en;
    logic [3:0]  i_data_wr_mask;
    logic [31:0] i_data_wr;
    logic        o_data_ack;
    logic [31:0] o_data_rd;
    logic        o_data_err;

    logic [31:0] o_mem_addr;
    logic        o_mem_wr_en;
    logic [3:0]  o_mem_wr_mask;
    logic [31:0] o_mem_wr_data;
    logic [31:0] i_mem_rd_data;

    modport slave (
        input  i_inst_req, i_inst_addr,
        output o_inst_ack, o_inst_data, o_inst_err,
        input  i_data_req, i_data_addr, i_data_wr_en, i_data_wr_mask, i_data_wr,
        output o_data_ack, o_data_rd, o_data_err,
        output o_mem_addr, o_mem_wr_en, o_mem_wr_mask, o_mem_wr_data,
        input  i_mem_rd_data
    );

    modport master (
        output i_inst_req, i_inst_addr,
        input  o_inst_ack, o_inst_data, o_inst_err,
        output i_data_req, i_data_addr, i_data_wr_en, i_data_wr_mask, i_data_wr,
        input  o_data_ack, o_data_rd, o_data_err,
        input  o_mem_addr, o_mem_wr_en, o_mem_wr_mask, o_mem_wr_data,
        output i_mem_rd_data
    );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-port memory between fetch and load/store. Load/store has priority;
// fetch is forced ahead once STARVE_LIMIT data grants have passed it by.
module rv32i_mem_arbiter #(
    parameter int unsigned MEMORY_DEPTH = 81920,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input logic                i_clk,
    input logic                i_rst_n,
    rv32i_mem_arbiter_if.slave bus
);
    typedef enum logic {StWait, StIssued} port_state_e;

    localparam logic [31:0] DepthLim  = 32'(MEMORY_DEPTH);
    localparam logic [3:0]  StarveMax = 4'(STARVE_LIMIT);

    port_state_e r_inst_state, r_data_state;
    logic        r_inst_pend_err, r_data_pend_err, r_data_pend_zero;
    logic        r_inst_ack, r_inst_err, r_data_ack, r_data_err, r_data_zero;
    logic [31:0] r_inst_hold, r_data_hold;
    logic [3:0]  r_starve;
    logic [31:0] r_mem_addr, r_mem_wr_data;
    logic        r_mem_wr_en;
    logic [3:0]  r_mem_wr_mask;

    logic        w_inst_elig, w_data_elig, w_starved, w_grant_inst, w_grant_data;
    logic        w_inst_oor, w_data_oor, w_store;
    logic [31:0] w_inst_data, w_data_rd;

    always_comb begin
        w_inst_elig  = bus.i_inst_req && (r_inst_state == StWait);
        w_data_elig  = bus.i_data_req && (r_data_state == StWait);
        w_starved    = (r_starve == StarveMax);
        w_grant_inst = w_inst_elig && (!w_data_elig || w_starved);
        w_grant_data = w_data_elig && !w_grant_inst;
        w_inst_oor   = (bus.i_inst_addr >= DepthLim);
        w_data_oor   = (bus.i_data_addr >= DepthLim);
        w_store      = bus.i_data_wr_en && !w_data_oor;
        // Memory read data is live only in the ack cycle; the hold registers cover the rest.
        w_inst_data  = r_inst_ack ? (r_inst_err ? '0 : bus.i_mem_rd_data) : r_inst_hold;
        w_data_rd    = r_data_ack ? (r_data_zero ? '0 : bus.i_mem_rd_data) : r_data_hold;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inst_state     <= StWait;
            r_data_state     <= StWait;
            r_inst_pend_err  <= 1'b0;
            r_data_pend_err  <= 1'b0;
            r_data_pend_zero <= 1'b0;
            r_inst_ack       <= 1'b0;
            r_inst_err       <= 1'b0;
            r_data_ack       <= 1'b0;
            r_data_err       <= 1'b0;
            r_data_zero      <= 1'b0;
            r_inst_hold      <= '0;
            r_data_hold      <= '0;
            r_starve         <= '0;
            r_mem_addr       <= '0;
            r_mem_wr_en      <= 1'b0;
            r_mem_wr_mask    <= '0;
            r_mem_wr_data    <= '0;
        end else begin
            r_inst_state     <= w_grant_inst ? StIssued : StWait;
            r_data_state     <= w_grant_data ? StIssued : StWait;
            r_inst_pend_err  <= w_grant_inst && w_inst_oor;
            r_data_pend_err  <= w_grant_data && w_data_oor;
            r_data_pend_zero <= w_grant_data && (w_data_oor || bus.i_data_wr_en);

            r_inst_ack  <= (r_inst_state == StIssued);
            r_inst_err  <= (r_inst_state == StIssued) && r_inst_pend_err;
            r_data_ack  <= (r_data_state == StIssued);
            r_data_err  <= (r_data_state == StIssued) && r_data_pend_err;
            r_data_zero <= (r_data_state == StIssued) && r_data_pend_zero;

            if (r_inst_ack) r_inst_hold <= w_inst_data;
            if (r_data_ack) r_data_hold <= w_data_rd;

            if (!bus.i_inst_req || w_grant_inst) begin
                r_starve <= '0;
            end else if (w_grant_data && w_inst_elig && !w_starved) begin
                r_starve <= r_starve + 4'd1;
            end

            if (w_grant_inst) begin
                r_mem_addr    <= {bus.i_inst_addr[31:2], 2'b00};
                r_mem_wr_en   <= 1'b0;
                r_mem_wr_mask <= '0;
                r_mem_wr_data <= '0;
            end else if (w_grant_data) begin
                // Out-of-range accesses still take the slot but never strobe memory.
                r_mem_addr    <= {bus.i_data_addr[31:2], 2'b00};
                r_mem_wr_en   <= w_store;
                r_mem_wr_mask <= w_store ? bus.i_data_wr_mask : '0;
                r_mem_wr_data <= w_store ? bus.i_data_wr : '0;
            end else begin
                r_mem_wr_en   <= 1'b0;
                r_mem_wr_mask <= '0;
                r_mem_wr_data <= '0;
            end
        end
    end

    assign bus.o_inst_ack    = r_inst_ack;
    assign bus.o_inst_err    = r_inst_err;
    assign bus.o_inst_data   = w_inst_data;
    assign bus.o_data_ack    = r_data_ack;
    assign bus.o_data_err    = r_data_err;
    assign bus.o_data_rd     = w_data_rd;
    assign bus.o_mem_addr    = r_mem_addr;
    assign bus.o_mem_wr_en   = r_mem_wr_en;
    assign bus.o_mem_wr_mask = r_mem_wr_mask;
    assign bus.o_mem_wr_data = r_mem_wr_data;
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: directed steps plus random traffic against a
// transaction-level reference model and a registered memory responder.
module tb_rv32i_mem_arbiter;
    localparam int unsigned DEPTH = 81920;
    localparam int unsigned LIMIT = 3;
    localparam int unsigned WORDS = DEPTH / 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rv32i_mem_arbiter_if bus();

    rv32i_mem_arbiter #(
        .MEMORY_DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int n_checks;
    int n_errs;

    function automatic logic [31:0] mem_init(int i);
        return 32'(i) * 32'h9E3779B1 + 32'h01234567;
    endfunction

    // Registered memory responder, driven only by the DUT's memory port (plus setup pokes).
    logic [31:0] mem [WORDS];
    logic        pk_fill = 1'b0;
    logic        pk_en = 1'b0;
    int          pk_idx = 0;
    logic [31:0] pk_val = '0;
    logic [31:0] wtmp;
    int          widx;
    always @(posedge clk) begin
        widx = int'(bus.o_mem_addr >> 2);
        if (pk_fill) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= mem_init(i);
        end else if (pk_en) begin
            mem[pk_idx] <= pk_val;
        end else if (bus.o_mem_wr_en && bus.o_mem_addr < DEPTH) begin
            wtmp = mem[widx];
            for (int b = 0; b < 4; b++)
                if (bus.o_mem_wr_mask[b]) wtmp[8*b +: 8] = bus.o_mem_wr_data[8*b +: 8];
            mem[widx] <= wtmp;
        end
        bus.i_mem_rd_data <= (bus.o_mem_addr < DEPTH) ? mem[widx] : 32'h0;
    end

    // Reference model: what each port should see, derived from the arbitration rules.
    logic [31:0] ref_mem [WORDS];
    bit          m_ib, m_db, m_i_err, m_d_err;
    logic [31:0] m_i_val, m_d_val, m_i_hold, m_d_hold, m_addr;
    int          m_starve;
    byte         glog[$];
    logic        e_iack, e_ierr, e_dack, e_derr, e_wr;
    logic [31:0] e_idata, e_drd, e_addr, e_wdata;
    logic [3:0]  e_mask;

    task automatic model_reset();
        m_ib = 0; m_db = 0; m_i_err = 0; m_d_err = 0;
        m_i_val = '0; m_d_val = '0; m_i_hold = '0; m_d_hold = '0; m_addr = '0;
        m_starve = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit ie, de, gi, gd, oor;
        int idx;
        ie = bus.i_inst_req && !m_ib;
        de = bus.i_data_req && !m_db;
        gi = ie && (!de || m_starve == LIMIT);
        gd = de && !gi;
        e_iack = m_ib;
        e_ierr = m_ib && m_i_err;
        if (m_ib) m_i_hold = m_i_val;
        e_idata = m_i_hold;
        e_dack = m_db;
        e_derr = m_db && m_d_err;
        if (m_db) m_d_hold = m_d_val;
        e_drd = m_d_hold;
        if (!bus.i_inst_req || gi) m_starve = 0;
        else if (gd && ie && m_starve < LIMIT) m_starve++;
        m_ib = gi;
        m_db = gd;
        e_wr = 0; e_mask = '0; e_wdata = '0;
        if (gi) begin
            oor = bus.i_inst_addr >= DEPTH;
            idx = int'(bus.i_inst_addr >> 2);
            m_addr = bus.i_inst_addr & ~32'h3;
            m_i_err = oor;
            m_i_val = oor ? 32'h0 : ref_mem[idx];
            glog.push_back("I");
        end else if (gd) begin
            oor = bus.i_data_addr >= DEPTH;
            idx = int'(bus.i_data_addr >> 2);
            m_addr = bus.i_data_addr & ~32'h3;
            m_d_err = oor;
            if (oor) m_d_val = 0;
            else if (bus.i_data_wr_en) begin
                m_d_val = 0;
                e_wr = 1; e_mask = bus.i_data_wr_mask; e_wdata = bus.i_data_wr;
                for (int b = 0; b < 4; b++)
                    if (e_mask[b]) ref_mem[idx][8*b +: 8] = e_wdata[8*b +: 8];
            end else m_d_val = ref_mem[idx];
            glog.push_back("D");
        end else glog.push_back("-");
        e_addr = m_addr;
        @(posedge clk);
        #1;
        chk("inst_ack", 32'(bus.o_inst_ack), 32'(e_iack));
        chk("inst_err", 32'(bus.o_inst_err), 32'(e_ierr));
        chk("inst_data", bus.o_inst_data, e_idata);
        chk("data_ack", 32'(bus.o_data_ack), 32'(e_dack));
        chk("data_err", 32'(bus.o_data_err), 32'(e_derr));
        chk("data_rd", bus.o_data_rd, e_drd);
        chk("mem_addr", bus.o_mem_addr, e_addr);
        chk("mem_wr_en", 32'(bus.o_mem_wr_en), 32'(e_wr));
        chk("mem_wr_mask", 32'(bus.o_mem_wr_mask), 32'(e_mask));
        chk("mem_wr_data", bus.o_mem_wr_data, e_wdata);
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        ref_mem[idx] = val;
        pk_idx = idx; pk_val = val; pk_en = 1'b1;
        step();
        pk_en = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 15) == 0) return 32'(DEPTH + $urandom_range(0, 4095));
        return 32'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic new_data_fields();
        bus.i_data_addr    = rnd_addr();
        bus.i_data_wr_en   = 1'($urandom_range(0, 1));
        bus.i_data_wr_mask = 4'($urandom_range(0, 15));
        bus.i_data_wr      = $urandom;
    endtask

    int viol, run, maxrun;

    initial begin
        n_checks = 0;
        n_errs = 0;
        bus.i_inst_req = 1'b1; bus.i_inst_addr = 32'h0;
        bus.i_data_req = 1'b1; bus.i_data_addr = 32'h200;
        bus.i_data_wr_en = 1'b0; bus.i_data_wr_mask = '0; bus.i_data_wr = '0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = mem_init(i);
        model_reset();
        #1 rst_n = 1'b0;
        pk_fill = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            pk_fill = 1'b0;
            chk("rst_inst_ack", 32'(bus.o_inst_ack), 0);
            chk("rst_data_ack", 32'(bus.o_data_ack), 0);
            chk("rst_errs", 32'({bus.o_inst_err, bus.o_data_err}), 0);
            chk("rst_wr_en", 32'(bus.o_mem_wr_en), 0);
            chk("rst_addr", bus.o_mem_addr, 0);
        end
        rst_n = 1'b1;
        step();
        chk("rst_first_grant", bus.o_mem_addr, 32'h200);
        step();
        chk("rst_first_ack", 32'(bus.o_data_ack), 1);
        bus.i_data_req = 1'b0;
        step();
        chk("rst_fetch_after", 32'(bus.o_inst_ack), 1);
        bus.i_inst_req = 1'b0;
        step();

        // Lone fetch with a held request.
        poke(4, 32'h00000013);
        bus.i_inst_req = 1'b1; bus.i_inst_addr = 32'h10;
        step();
        chk("fetch_addr", bus.o_mem_addr, 32'h10);
        step();
        chk("fetch_ack", 32'(bus.o_inst_ack), 1);
        chk("fetch_data", bus.o_inst_data, 32'h13);
        step();
        chk("fetch_gap", 32'(bus.o_inst_ack), 0);
        step();
        chk("fetch_ack2", 32'(bus.o_inst_ack), 1);
        bus.i_inst_req = 1'b0;
        step();
        chk("fetch_hold", bus.o_inst_data, 32'h13);

        // Store then load.
        bus.i_data_req = 1'b1; bus.i_data_addr = 32'h1004;
        bus.i_data_wr_en = 1'b1; bus.i_data_wr_mask = 4'hF; bus.i_data_wr = 32'hDEADBEEF;
        step();
        chk("store_strobe", 32'(bus.o_mem_wr_en), 1);
        chk("store_wdata", bus.o_mem_wr_data, 32'hDEADBEEF);
        step();
        chk("store_ack", 32'(bus.o_data_ack), 1);
        chk("store_rd_zero", bus.o_data_rd, 0);
        chk("store_one_strobe", 32'(bus.o_mem_wr_en), 0);
        bus.i_data_req = 1'b0;
        step();
        bus.i_data_req = 1'b1; bus.i_data_wr_en = 1'b0; bus.i_data_wr_mask = '0;
        bus.i_data_wr = '0;
        step();
        step();
        chk("load_back", bus.o_data_rd, 32'hDEADBEEF);
        bus.i_data_req = 1'b0;
        step();

        // Out-of-range load and store.
        bus.i_data_req = 1'b1; bus.i_data_addr = 32'h00014000;
        step();
        chk("oor_load_nostrobe", 32'(bus.o_mem_wr_en), 0);
        step();
        chk("oor_load_ack", 32'(bus.o_data_ack), 1);
        chk("oor_load_err", 32'(bus.o_data_err), 1);
        chk("oor_load_rd", bus.o_data_rd, 0);
        bus.i_data_req = 1'b0;
        step();
        bus.i_data_req = 1'b1; bus.i_data_addr = 32'h00014004;
        bus.i_data_wr_en = 1'b1; bus.i_data_wr_mask = 4'hF; bus.i_data_wr = 32'h12345678;
        step();
        chk("oor_store_nostrobe", 32'(bus.o_mem_wr_en), 0);
        step();
        chk("oor_store_err", 32'(bus.o_data_err), 1);
        bus.i_data_req = 1'b0; bus.i_data_wr_en = 1'b0;
        step();

        // Reset in the cycle after a fetch issue.
        bus.i_inst_req = 1'b1; bus.i_inst_addr = 32'h10;
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_async_addr", bus.o_mem_addr, 0);
        @(posedge clk);
        #1;
        chk("midrst_noack", 32'(bus.o_inst_ack), 0);
        rst_n = 1'b1;
        model_reset();
        step();
        chk("midrst_noack_after", 32'(bus.o_inst_ack), 0);
        chk("midrst_reissue", bus.o_mem_addr, 32'h10);
        step();
        chk("midrst_ack", 32'(bus.o_inst_ack), 1);
        chk("midrst_data", bus.o_inst_data, 32'h13);
        bus.i_inst_req = 1'b0;
        step();

        // Continuous contention: grants must alternate, data first.
        glog.delete();
        bus.i_inst_req = 1'b1; bus.i_inst_addr = 32'h40;
        bus.i_data_req = 1'b1; bus.i_data_addr = 32'h80; bus.i_data_wr_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (e_iack) bus.i_inst_addr = 32'($urandom_range(0, DEPTH - 1));
            if (e_dack) bus.i_data_addr = 32'($urandom_range(0, DEPTH - 1));
        end
        viol = 0; run = 0; maxrun = 0;
        for (int i = 0; i < glog.size(); i++) begin
            if (i > 0 && (glog[i] == glog[i-1] || glog[i] == "-")) viol++;
            run = (glog[i] == "D") ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        chk("contention_first", 32'(glog[0]), 32'("D"));
        chk("contention_alt", 32'(viol), 0);
        chk("starve_bound", 32'(maxrun <= LIMIT), 1);
        bus.i_inst_req = 1'b0; bus.i_data_req = 1'b0;
        step();
        step();

        // Random traffic, including abandoned requests.
        for (int k = 0; k < 2000; k++) begin
            step();
            if (e_iack || !bus.i_inst_req) begin
                bus.i_inst_req = 1'($urandom_range(0, 2) != 0);
                bus.i_inst_addr = rnd_addr();
            end else if ($urandom_range(0, 63) == 0) bus.i_inst_req = 1'b0;
            if (e_dack || !bus.i_data_req) begin
                bus.i_data_req = 1'($urandom_range(0, 2) != 0);
                new_data_fields();
            end else if ($urandom_range(0, 63) == 0) bus.i_data_req = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
